// File: rtl/drp_pkg.sv
// drp_pkg: shared FSM encoding and DRP data constants for the DRP arbiter
package drp_pkg;
  typedef enum logic {IDLE, WAIT} drp_state_t;
  localparam int DRP_DW = 16;
  localparam logic [DRP_DW-1:0] DRP_TIMEOUT_DATA = 16'hFFFF;
endpackage

// File: rtl/drp_req_latch.sv
// drp_req_latch: holds one master's DRP request until granted; drops strobes while pending or in flight
module drp_req_latch
  import drp_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DRP_DW-1:0]     i_do,
  input  logic                  i_inflight,
  input  logic                  i_clr,
  output logic                  o_pending,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DRP_DW-1:0]     o_do
);
  logic                  r_pending;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DRP_DW-1:0]     r_do;
  logic                  w_accept;

  assign w_accept  = i_en && !r_pending && !i_inflight;
  assign o_pending = r_pending;
  assign o_we      = r_we;
  assign o_addr    = r_addr;
  assign o_do      = r_do;

  // capture an accepted request; the grant clears pending (never coincides with an accept)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_do      <= '0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_we      <= i_we;
      r_addr    <= i_addr;
      r_do      <= i_do;
    end else if (i_clr) begin
      r_pending <= 1'b0;
    end
  end
endmodule

// File: rtl/drp_arbiter.sv
// drp_arbiter: round-robin two-master DRP arbiter, one transaction in flight; define DRP_ARB_TIMEOUT_EN to force completion after TIMEOUT cycles
module drp_arbiter
  import drp_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s0_drp_addr,
  input  logic [DRP_DW-1:0]     s0_drp_do,
  output logic [DRP_DW-1:0]     s0_drp_di,
  input  logic                  s0_drp_en,
  input  logic                  s0_drp_we,
  output logic                  s0_drp_rdy,
  input  logic [ADDR_WIDTH-1:0] s1_drp_addr,
  input  logic [DRP_DW-1:0]     s1_drp_do,
  output logic [DRP_DW-1:0]     s1_drp_di,
  input  logic                  s1_drp_en,
  input  logic                  s1_drp_we,
  output logic                  s1_drp_rdy,
  output logic [ADDR_WIDTH-1:0] m_drp_addr,
  output logic [DRP_DW-1:0]     m_drp_do,
  input  logic [DRP_DW-1:0]     m_drp_di,
  output logic                  m_drp_en,
  output logic                  m_drp_we,
  input  logic                  m_drp_rdy,
  output logic                  busy,
  output logic                  timeout
);
  drp_state_t            r_state, w_next;
  logic                  w_pend0, w_pend1, w_we0, w_we1;
  logic [ADDR_WIDTH-1:0] w_addr0, w_addr1;
  logic [DRP_DW-1:0]     w_do0, w_do1, w_rsp;
  logic                  w_grant, w_gnt_port, w_done, w_to_hit;
  logic                  r_owner, r_last;

  drp_req_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_req0 (
    .clk(clk), .rst(rst),
    .i_en(s0_drp_en), .i_we(s0_drp_we), .i_addr(s0_drp_addr), .i_do(s0_drp_do),
    .i_inflight(busy && !r_owner), .i_clr(w_grant && !w_gnt_port),
    .o_pending(w_pend0), .o_we(w_we0), .o_addr(w_addr0), .o_do(w_do0)
  );

  drp_req_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_req1 (
    .clk(clk), .rst(rst),
    .i_en(s1_drp_en), .i_we(s1_drp_we), .i_addr(s1_drp_addr), .i_do(s1_drp_do),
    .i_inflight(busy && r_owner), .i_clr(w_grant && w_gnt_port),
    .o_pending(w_pend1), .o_we(w_we1), .o_addr(w_addr1), .o_do(w_do1)
  );

`ifdef DRP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  // wait-cycle counter, restarted on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (w_grant) r_cnt <= '0;
    else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
  end

  assign w_to_hit = (r_state == WAIT) && (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_to_hit = (TIMEOUT < 0);
`endif

  // grant selection: on a tie the port not granted last wins; completion by ready or timeout
  always_comb begin
    w_grant    = (r_state == IDLE) && (w_pend0 || w_pend1);
    w_gnt_port = (w_pend0 && w_pend1) ? !r_last : w_pend1;
    w_done     = (r_state == WAIT) && (m_drp_rdy || w_to_hit);
    w_rsp      = m_drp_rdy ? m_drp_di : DRP_TIMEOUT_DATA;
    w_next     = w_grant ? WAIT : (w_done ? IDLE : r_state);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // registered transceiver request, response routing and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_drp_en   <= 1'b0;
      m_drp_we   <= 1'b0;
      m_drp_addr <= '0;
      m_drp_do   <= '0;
      s0_drp_rdy <= 1'b0;
      s1_drp_rdy <= 1'b0;
      s0_drp_di  <= '0;
      s1_drp_di  <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
    end else begin
      m_drp_en   <= w_grant;
      s0_drp_rdy <= w_done && !r_owner;
      s1_drp_rdy <= w_done && r_owner;
      timeout    <= w_done && !m_drp_rdy;
      if (w_grant) begin
        m_drp_addr <= w_gnt_port ? w_addr1 : w_addr0;
        m_drp_do   <= w_gnt_port ? w_do1 : w_do0;
        m_drp_we   <= w_gnt_port ? w_we1 : w_we0;
        r_owner    <= w_gnt_port;
        r_last     <= w_gnt_port;
        busy       <= 1'b1;
      end else if (w_done) begin
        busy <= 1'b0;
      end
      if (w_done && r_owner) s1_drp_di <= w_rsp;
      if (w_done && !r_owner) s0_drp_di <= w_rsp;
    end
  end
endmodule

// File: tb/tb_drp_arbiter.sv
// tb_drp_arbiter: directed vector table plus hand sequences for contention, drop, timeout and reset
module tb_drp_arbiter;
  logic        clk = 0, rst = 1;
  logic [9:0]  s0_drp_addr = 0, s1_drp_addr = 0, m_drp_addr;
  logic [15:0] s0_drp_do = 0, s1_drp_do = 0, s0_drp_di, s1_drp_di, m_drp_do, m_drp_di = 0;
  logic        s0_drp_en = 0, s0_drp_we = 0, s0_drp_rdy, s1_drp_en = 0, s1_drp_we = 0, s1_drp_rdy;
  logic        m_drp_en, m_drp_we, m_drp_rdy = 0, busy, timeout;
  int          n_checks = 0, n_err = 0, n_men = 0, n_rdy0 = 0;
  logic [15:0] last_di [2];

  drp_arbiter #(.ADDR_WIDTH(10), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .s0_drp_addr(s0_drp_addr), .s0_drp_do(s0_drp_do), .s0_drp_di(s0_drp_di),
    .s0_drp_en(s0_drp_en), .s0_drp_we(s0_drp_we), .s0_drp_rdy(s0_drp_rdy),
    .s1_drp_addr(s1_drp_addr), .s1_drp_do(s1_drp_do), .s1_drp_di(s1_drp_di),
    .s1_drp_en(s1_drp_en), .s1_drp_we(s1_drp_we), .s1_drp_rdy(s1_drp_rdy),
    .m_drp_addr(m_drp_addr), .m_drp_do(m_drp_do), .m_drp_di(m_drp_di),
    .m_drp_en(m_drp_en), .m_drp_we(m_drp_we), .m_drp_rdy(m_drp_rdy),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_drp_en) n_men++;
    if (s0_drp_rdy) n_rdy0++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wd;
    logic [15:0] rd;
    int          lat;
    logic [9:0]  exp_addr;
    logic        exp_we;
    logic [15:0] exp_do;
    logic [15:0] exp_di;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic req(input logic p, input logic we, input logic [9:0] a, input logic [15:0] d);
    if (p) begin
      s1_drp_en = 1; s1_drp_we = we; s1_drp_addr = a; s1_drp_do = d;
    end else begin
      s0_drp_en = 1; s0_drp_we = we; s0_drp_addr = a; s0_drp_do = d;
    end
  endtask

  task automatic idle_in();
    s0_drp_en = 0; s1_drp_en = 0; s0_drp_we = 0; s1_drp_we = 0;
  endtask

  task automatic check_rsp(input string name, input logic p, input logic [15:0] d);
    check({name, " rdy_owner"}, p ? s1_drp_rdy : s0_drp_rdy, 1);
    check({name, " rdy_other"}, p ? s0_drp_rdy : s1_drp_rdy, 0);
    check({name, " di_owner"}, p ? s1_drp_di : s0_drp_di, d);
    check({name, " di_other"}, p ? s0_drp_di : s1_drp_di, last_di[!p]);
    last_di[p] = d;
  endtask

  task automatic respond(input int lat, input logic [15:0] d);
    repeat (lat) begin
      step();
      check("wait no en", m_drp_en, 0);
    end
    check("busy in R", busy, 1);
    m_drp_rdy = 1; m_drp_di = d;
    step();
    m_drp_rdy = 0;
  endtask

  task automatic run_vec(input vec_t v);
    req(v.port, v.we, v.addr, v.wd);
    step();
    idle_in();
    check("vec en T+1", m_drp_en, 0);
    step();
    check("vec m_en", m_drp_en, 1);
    check("vec m_addr", m_drp_addr, v.exp_addr);
    check("vec m_we", m_drp_we, v.exp_we);
    check("vec m_do", m_drp_do, v.exp_do);
    respond(v.lat, v.rd);
    check_rsp("vec", v.port, v.exp_di);
    check("vec busy off", busy, 0);
    check("vec timeout", timeout, 0);
  endtask

  initial begin
    vec_t vecs [6];
    int   e0, r0;
    vecs[0] = '{1'b0, 1'b0, 10'h07C, 16'h0000, 16'h1234, 3, 10'h07C, 1'b0, 16'h0000, 16'h1234};
    vecs[1] = '{1'b1, 1'b0, 10'h001, 16'h0000, 16'h0A01, 0, 10'h001, 1'b0, 16'h0000, 16'h0A01};
    vecs[2] = '{1'b1, 1'b0, 10'h002, 16'h0000, 16'h0A02, 1, 10'h002, 1'b0, 16'h0000, 16'h0A02};
    vecs[3] = '{1'b1, 1'b0, 10'h003, 16'h0000, 16'h0A03, 2, 10'h003, 1'b0, 16'h0000, 16'h0A03};
    vecs[4] = '{1'b0, 1'b1, 10'h3FF, 16'hBEEF, 16'h0000, 1, 10'h3FF, 1'b1, 16'hBEEF, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 10'h155, 16'h0F0F, 16'h7777, 4, 10'h155, 1'b1, 16'h0F0F, 16'h7777};
    last_di[0] = 0; last_di[1] = 0;

    step(); step();
    check("rst m_en", m_drp_en, 0);
    check("rst m_addr", m_drp_addr, 0);
    check("rst busy", busy, 0);
    check("rst rdy", {s0_drp_rdy, s1_drp_rdy}, 0);
    check("rst di", {s0_drp_di, s1_drp_di}, 0);
    check("rst timeout", timeout, 0);
    rst = 0;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // contention, repeated twice: s0 must win both times
    for (int k = 0; k < 2; k++) begin
      req(0, 1, 10'h010, 16'hAAAA);
      req(1, 1, 10'h020, 16'h5555);
      step();
      idle_in();
      step();
      check("cont first en", m_drp_en, 1);
      check("cont first addr", m_drp_addr, 10'h010);
      check("cont first do", m_drp_do, 16'hAAAA);
      respond(1, 16'h00C0);
      check_rsp("cont s0", 0, 16'h00C0);
      check("cont no en R+1", m_drp_en, 0);
      step();
      check("cont second en", m_drp_en, 1);
      check("cont second addr", m_drp_addr, 10'h020);
      check("cont second do", m_drp_do, 16'h5555);
      respond(0, 16'h00C1);
      check_rsp("cont s1", 1, 16'h00C1);
    end

    // repeated strobes while pending and while in flight are dropped
    e0 = n_men; r0 = n_rdy0;
    req(0, 0, 10'h040, 0);
    step();
    req(0, 0, 10'h041, 0);
    step();
    check("drop en", m_drp_en, 1);
    check("drop addr", m_drp_addr, 10'h040);
    req(0, 0, 10'h042, 0);
    step();
    idle_in();
    m_drp_rdy = 1; m_drp_di = 16'h4040;
    step();
    m_drp_rdy = 0;
    check_rsp("drop", 0, 16'h4040);
    repeat (5) step();
    check("drop en count", n_men - e0, 1);
    check("drop rdy count", n_rdy0 - r0, 1);

    req(0, 0, 10'h0AA, 0);
    step();
    idle_in();
    step();
    check("to en", m_drp_en, 1);
`ifdef DRP_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      step();
      check("to early rdy", s0_drp_rdy, 0);
    end
    step();
    check("to rdy", s0_drp_rdy, 1);
    check("to di", s0_drp_di, 16'hFFFF);
    check("to pulse", timeout, 1);
    check("to busy", busy, 0);
    last_di[0] = 16'hFFFF;
    m_drp_rdy = 1; m_drp_di = 16'h1111;
    step();
    m_drp_rdy = 0;
    check("late rdy ignored", {s0_drp_rdy, s1_drp_rdy, timeout}, 0);
    check("late di held", s0_drp_di, 16'hFFFF);
`else
    repeat (20) step();
    check("nto busy", busy, 1);
    check("nto rdy", s0_drp_rdy, 0);
    check("nto timeout", timeout, 0);
    respond(0, 16'h2222);
    check_rsp("nto", 0, 16'h2222);
`endif

    // async reset mid-transaction
    step();
    req(0, 1, 10'h123, 16'h9999);
    step();
    idle_in();
    step();
    check("ar en", m_drp_en, 1);
    #2 rst = 1;
    #1;
    check("ar m_en", m_drp_en, 0);
    check("ar m_addr", m_drp_addr, 0);
    check("ar m_do", m_drp_do, 0);
    check("ar busy", busy, 0);
    check("ar di", {s0_drp_di, s1_drp_di}, 0);
    last_di[0] = 0; last_di[1] = 0;
    step();
    rst = 0;
    step();
    check("ar no rdy", {s0_drp_rdy, s1_drp_rdy}, 0);
    req(1, 0, 10'h2A5, 0);
    step();
    idle_in();
    step();
    check("ar new en", m_drp_en, 1);
    check("ar new addr", m_drp_addr, 10'h2A5);
    respond(2, 16'h5A5A);
    check_rsp("ar new", 1, 16'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
